// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state, unit-select, error and opcode constants for the ALU command sequencer
package alu_seq_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;
  localparam logic [1:0] ERR_OK = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_NOP = 4'b1000;
endpackage

// File: rtl/alu_result_sel.sv
// alu_result_sel: picks the selected unit's flag/result and zero-extends narrow results
module alu_result_sel
  import alu_seq_pkg::*;
#(
  parameter int OUT_WIDTH = 16,
  parameter int ARITH_WIDTH = 32
) (
  input  logic [1:0]             unit_i,
  input  logic [ARITH_WIDTH-1:0] arith_i,
  input  logic                   carry_i,
  input  logic [OUT_WIDTH-1:0]   logic_i,
  input  logic [OUT_WIDTH-1:0]   cmp_i,
  input  logic [OUT_WIDTH-1:0]   shift_i,
  input  logic                   arith_flag_i,
  input  logic                   logic_flag_i,
  input  logic                   cmp_flag_i,
  input  logic                   shift_flag_i,
  output logic [ARITH_WIDTH-1:0] data_o,
  output logic                   carry_o,
  output logic                   flag_o
);
  // only the selected unit's flag counts; carry is meaningful for arithmetic only
  always_comb begin
    data_o = unit_i == UNIT_ARITH ? arith_i :
             unit_i == UNIT_LOGIC ? ARITH_WIDTH'(logic_i) :
             unit_i == UNIT_CMP   ? ARITH_WIDTH'(cmp_i) : ARITH_WIDTH'(shift_i);
    flag_o = unit_i == UNIT_ARITH ? arith_flag_i :
             unit_i == UNIT_LOGIC ? logic_flag_i :
             unit_i == UNIT_SHIFT ? shift_flag_i : cmp_flag_i;
    carry_o = unit_i == UNIT_ARITH && carry_i;
  end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issues one command to the ALU, waits for its unit flag, returns the result
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int IN_WIDTH = 16,
  parameter int OUT_WIDTH = 16,
  parameter int ARITH_WIDTH = 32,
  parameter int TIMEOUT = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CMD_VALID,
  output logic                   CMD_READY,
  input  logic [3:0]             CMD_OP,
  input  logic [IN_WIDTH-1:0]    CMD_A,
  input  logic [IN_WIDTH-1:0]    CMD_B,
  output logic [IN_WIDTH-1:0]    ALU_A,
  output logic [IN_WIDTH-1:0]    ALU_B,
  output logic [3:0]             ALU_FUN,
  output logic                   ALU_EN,
  input  logic [ARITH_WIDTH-1:0] Arith_OUT,
  input  logic                   Carry_OUT,
  input  logic [OUT_WIDTH-1:0]   Logic_OUT,
  input  logic [OUT_WIDTH-1:0]   CMP_OUT,
  input  logic [OUT_WIDTH-1:0]   Shift_OUT,
  input  logic                   Arith_Flag,
  input  logic                   Logic_Flag,
  input  logic                   CMP_Flag,
  input  logic                   Shift_Flag,
  output logic                   RES_VALID,
  input  logic                   RES_READY,
  output logic [ARITH_WIDTH-1:0] RES_DATA,
  output logic                   RES_CARRY,
  output logic [1:0]             RES_ERR
);
  state_e state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [IN_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0] fun_q, fun_d;
  logic [ARITH_WIDTH-1:0] data_q, data_d, sel_data;
  logic carry_q, carry_d, sel_carry, sel_flag;
  logic [1:0] err_q, err_d;
  alu_result_sel #(.OUT_WIDTH(OUT_WIDTH), .ARITH_WIDTH(ARITH_WIDTH)) u_sel (
    .unit_i(fun_q[3:2]), .arith_i(Arith_OUT), .carry_i(Carry_OUT), .logic_i(Logic_OUT),
    .cmp_i(CMP_OUT), .shift_i(Shift_OUT), .arith_flag_i(Arith_Flag), .logic_flag_i(Logic_Flag),
    .cmp_flag_i(CMP_Flag), .shift_flag_i(Shift_Flag), .data_o(sel_data), .carry_o(sel_carry),
    .flag_o(sel_flag)
  );
  assign CMD_READY = state_q == S_IDLE;
  assign ALU_EN = state_q == S_ISSUE;
  assign RES_VALID = state_q == S_RESP;
  assign ALU_A = a_q;
  assign ALU_B = b_q;
  assign ALU_FUN = fun_q;
  assign RES_DATA = data_q;
  assign RES_CARRY = carry_q;
  assign RES_ERR = err_q;
  // next-state: divide-by-zero skips the ALU, WAIT ends on the selected flag or the timeout
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    fun_d = fun_q;
    data_d = data_q;
    carry_d = carry_q;
    err_d = err_q;
    case (state_q)
      S_IDLE: if (CMD_VALID) begin
        a_d = CMD_A;
        b_d = CMD_B;
        fun_d = CMD_OP;
        if (CMD_OP == OP_DIV && CMD_B == '0) begin
          state_d = S_RESP;
          data_d = '1;
          carry_d = 1'b0;
          err_d = ERR_DIV0;
        end else state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d = '0;
      end
      S_WAIT: if (sel_flag) begin
        state_d = S_RESP;
        data_d = sel_data;
        carry_d = sel_carry;
        err_d = ERR_OK;
      end else if (cnt_q == CNT_WIDTH'(TIMEOUT - 1)) begin
        state_d = S_RESP;
        data_d = '0;
        carry_d = 1'b0;
        err_d = ERR_TIMEOUT;
      end else cnt_d = cnt_q + 1'b1;
      default: if (RES_READY) state_d = S_IDLE;
    endcase
  end
  // state and datapath registers; reset discards any pending command or result
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      fun_q <= '0;
      data_q <= '0;
      carry_q <= 1'b0;
      err_q <= ERR_OK;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      fun_q <= fun_d;
      data_q <= data_d;
      carry_q <= carry_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed checks of handshake, unit selection, traps and reset
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;
  logic CLK = 0, RST = 1, CMD_VALID = 0, CMD_READY, ALU_EN, Carry_OUT = 0;
  logic [3:0] CMD_OP = 0, ALU_FUN;
  logic [15:0] CMD_A = 0, CMD_B = 0, ALU_A, ALU_B, Logic_OUT = 0, CMP_OUT = 0, Shift_OUT = 0;
  logic [31:0] Arith_OUT = 0, RES_DATA;
  logic Arith_Flag = 0, Logic_Flag = 0, CMP_Flag = 0, Shift_Flag = 0;
  logic RES_VALID, RES_READY = 1, RES_CARRY;
  logic [1:0] RES_ERR;
  int total = 0, bad = 0;
  always #5 CLK = ~CLK;
  alu_cmd_sequencer dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_A(CMD_A), .CMD_B(CMD_B), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
    .ALU_EN(ALU_EN), .Arith_OUT(Arith_OUT), .Carry_OUT(Carry_OUT), .Logic_OUT(Logic_OUT),
    .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT), .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
    .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .RES_DATA(RES_DATA), .RES_CARRY(RES_CARRY), .RES_ERR(RES_ERR)
  );
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(CMD_READY), 1);
    chk({tag, "_valid"}, 32'(RES_VALID), 0);
    chk({tag, "_en"}, 32'(ALU_EN), 0);
    chk({tag, "_a"}, 32'(ALU_A), 0);
    chk({tag, "_b"}, 32'(ALU_B), 0);
    chk({tag, "_fun"}, 32'(ALU_FUN), 0);
    chk({tag, "_data"}, RES_DATA, 0);
    chk({tag, "_carry"}, 32'(RES_CARRY), 0);
    chk({tag, "_err"}, 32'(RES_ERR), 0);
  endtask
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    CMD_OP = op;
    CMD_A = a;
    CMD_B = b;
    CMD_VALID = 1;
    tick();
    CMD_VALID = 0;
    chk("issue_en", 32'(ALU_EN), 1);
    chk("issue_ready", 32'(CMD_READY), 0);
    tick();
    chk("wait_en", 32'(ALU_EN), 0);
    chk("wait_valid", 32'(RES_VALID), 0);
  endtask
  initial begin
    tick();
    tick();
    RST = 0;
    chk_reset("rst");
    issue(OP_ADD, 16'hFFFC, 16'hFFF6);
    chk("add_a", 32'(ALU_A), 32'hFFFC);
    chk("add_b", 32'(ALU_B), 32'hFFF6);
    Arith_OUT = 32'hFFFFFFF2;
    Carry_OUT = 1;
    Arith_Flag = 1;
    tick();
    Arith_Flag = 0;
    Arith_OUT = 32'h12345678;
    chk("add_valid", 32'(RES_VALID), 1);
    chk("add_data", RES_DATA, 32'hFFFFFFF2);
    chk("add_err", 32'(RES_ERR), 0);
    chk("add_carry", 32'(RES_CARRY), 1);
    tick();
    chk("add_idle", 32'(CMD_READY), 1);
    chk("add_done", 32'(RES_VALID), 0);
    CMD_OP = OP_DIV;
    CMD_A = 4;
    CMD_B = 0;
    CMD_VALID = 1;
    tick();
    CMD_VALID = 0;
    chk("div_en", 32'(ALU_EN), 0);
    chk("div_valid", 32'(RES_VALID), 1);
    chk("div_err", 32'(RES_ERR), 1);
    chk("div_data", RES_DATA, 32'hFFFFFFFF);
    chk("div_carry", 32'(RES_CARRY), 0);
    chk("div_fun", 32'(ALU_FUN), 32'(OP_DIV));
    tick();
    chk("div_idle", 32'(CMD_READY), 1);
    RES_READY = 0;
    issue(OP_MUL, 16'h0004, 16'hFFF6);
    Arith_OUT = 32'hFFFFFFD8;
    Carry_OUT = 0;
    Arith_Flag = 1;
    tick();
    Arith_Flag = 0;
    Arith_OUT = 32'hAAAAAAAA;
    for (int i = 0; i < 5; i++) begin
      chk("mul_data", RES_DATA, 32'hFFFFFFD8);
      chk("mul_valid", 32'(RES_VALID), 1);
      chk("mul_ready", 32'(CMD_READY), 0);
      tick();
    end
    RES_READY = 1;
    chk("mul_hold", 32'(RES_VALID), 1);
    tick();
    chk("mul_idle", 32'(CMD_READY), 1);
    Logic_OUT = 16'h5A5A;
    issue(4'b0100, 16'h00F0, 16'h0F0F);
    Arith_Flag = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("to_wait", 32'(RES_VALID), 0);
    end
    tick();
    Arith_Flag = 0;
    chk("to_valid", 32'(RES_VALID), 1);
    chk("to_err", 32'(RES_ERR), 2);
    chk("to_data", RES_DATA, 0);
    chk("to_carry", 32'(RES_CARRY), 0);
    tick();
    issue(4'b1101, 16'h0004, 16'h0001);
    Shift_OUT = 16'h8008;
    Logic_OUT = 16'hFFFF;
    Carry_OUT = 1;
    Logic_Flag = 1;
    Shift_Flag = 1;
    tick();
    Logic_Flag = 0;
    Shift_Flag = 0;
    chk("shf_data", RES_DATA, 32'h00008008);
    chk("shf_carry", 32'(RES_CARRY), 0);
    chk("shf_err", 32'(RES_ERR), 0);
    tick();
    issue(OP_NOP, 16'h0001, 16'h0002);
    CMP_OUT = 0;
    CMP_Flag = 1;
    tick();
    CMP_Flag = 0;
    chk("nop_data", RES_DATA, 0);
    chk("nop_err", 32'(RES_ERR), 0);
    chk("nop_valid", 32'(RES_VALID), 1);
    tick();
    issue(4'b1010, 16'h0007, 16'h0003);
    CMP_OUT = 16'h8001;
    CMP_Flag = 1;
    tick();
    CMP_Flag = 0;
    chk("cmp_data", RES_DATA, 32'h00008001);
    tick();
    issue(OP_SUB, 16'h0009, 16'h0002);
    RST = 1;
    tick();
    RST = 0;
    chk_reset("rstw");
    RES_READY = 0;
    issue(OP_ADD, 16'h0003, 16'h0005);
    Arith_OUT = 32'h00000008;
    Carry_OUT = 1;
    Arith_Flag = 1;
    tick();
    Arith_Flag = 0;
    chk("pre_rst_valid", 32'(RES_VALID), 1);
    RST = 1;
    tick();
    RST = 0;
    chk_reset("rstr");
    RES_READY = 1;
    tick();
    chk("post_rst_valid", 32'(RES_VALID), 0);
    chk("post_rst_en", 32'(ALU_EN), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
